// File: rtl/corr_sequencer.sv
// Frame sequencer for the correlator: loads F1, loads F2, processes, then sends,
// with per-stage timeout, abort, sticky error flags and shared-BRAM ownership.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | waiting for a run request on cfg_valid/cfg_ready
// S_LOAD_F1  | F1 loader running, owns BRAM
// S_LOAD_F2  | F2 loader running, owns BRAM
// S_PROCESS  | processor running, owns BRAM
// S_SEND     | result sender running, BRAM released
module corr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [12:0] cfg_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        abort,
  input  logic        err_clear,
  output logic        recv1_start,
  output logic        recv2_start,
  output logic        proc_start,
  output logic        send_start,
  input  logic        recv1_done,
  input  logic        recv2_done,
  input  logic        proc_done,
  input  logic        send_done,
  output logic [12:0] n_out,
  output logic [1:0]  bram_owner,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        timeout_err,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_F1,
    S_LOAD_F2,
    S_PROCESS,
    S_SEND
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cfg_ready_q, cfg_ready_d;
  logic [3:0]  start_q, start_d;
  logic [12:0] n_q, n_d;
  logic [1:0]  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        tmo_q, tmo_d;
  logic        cerr_q, cerr_d;

  logic accept;
  logic stage_done;
  logic tmo_hit;
  logic entering;

  // State register and per-stage cycle counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; done is ignored in a stage's start cycle and abort has top priority
  always_comb begin
    accept     = (state_q == S_IDLE) && cfg_valid && cfg_ready_q && !abort;
    stage_done = 1'b0;
    case (state_q)
      S_LOAD_F1: stage_done = recv1_done && !start_q[0];
      S_LOAD_F2: stage_done = recv2_done && !start_q[1];
      S_PROCESS: stage_done = proc_done && !start_q[2];
      S_SEND:    stage_done = send_done && !start_q[3];
      default:   stage_done = 1'b0;
    endcase
    tmo_hit = TMO_EN && (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (cfg_n != '0)) state_d = S_LOAD_F1;
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (stage_done) begin
          case (state_q)
            S_LOAD_F1: state_d = S_LOAD_F2;
            S_LOAD_F2: state_d = S_PROCESS;
            S_PROCESS: state_d = S_SEND;
            default:   state_d = S_IDLE;
          endcase
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
    endcase

    entering = (state_d != state_q);
    cnt_d    = (entering || (state_d == S_IDLE)) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output logic: next values of the registered outputs, derived from the next state
  always_comb begin
    start_d = 4'b0000;
    if (entering) begin
      case (state_d)
        S_LOAD_F1: start_d[0] = 1'b1;
        S_LOAD_F2: start_d[1] = 1'b1;
        S_PROCESS: start_d[2] = 1'b1;
        S_SEND:    start_d[3] = 1'b1;
        default:   start_d = 4'b0000;
      endcase
    end

    case (state_d)
      S_LOAD_F1: owner_d = 2'd1;
      S_LOAD_F2: owner_d = 2'd2;
      S_PROCESS: owner_d = 2'd3;
      default:   owner_d = 2'd0;
    endcase

    busy_d      = (state_d != S_IDLE);
    n_d         = (accept && (cfg_n != '0)) ? cfg_n : n_q;
    fdone_d     = (state_q == S_SEND) && stage_done && !abort;
    frame_cnt_d = frame_cnt_q + 16'(fdone_d);
    tmo_d       = ((state_q != S_IDLE) && !abort && !stage_done && tmo_hit) || (tmo_q && !err_clear);
    cerr_d      = (accept && (cfg_n == '0)) || (cerr_q && !err_clear);
    cfg_ready_d = (state_d == S_IDLE) && !tmo_d && !abort;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_ready_q <= 1'b0;
      start_q     <= 4'b0000;
      n_q         <= '0;
      owner_q     <= 2'd0;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      frame_cnt_q <= '0;
      tmo_q       <= 1'b0;
      cerr_q      <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      start_q     <= start_d;
      n_q         <= n_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      fdone_q     <= fdone_d;
      frame_cnt_q <= frame_cnt_d;
      tmo_q       <= tmo_d;
      cerr_q      <= cerr_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign recv1_start = start_q[0];
  assign recv2_start = start_q[1];
  assign proc_start  = start_q[2];
  assign send_start  = start_q[3];
  assign n_out       = n_q;
  assign bram_owner  = owner_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = tmo_q;
  assign cfg_err     = cerr_q;

endmodule

// File: tb/tb_corr_sequencer.sv
// Scoreboarded bench for corr_sequencer: expected start/frame_done pulses are queued with
// their expected cycle when a run is requested, and popped as the DUT produces them.
module tb_corr_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [12:0] cfg_n = '0;
  logic        cfg_valid = 1'b0;
  logic        abort = 1'b0;
  logic        err_clear = 1'b0;
  logic [3:0]  done_v = 4'b0000;

  logic        cfg_ready;
  logic        recv1_start, recv2_start, proc_start, send_start;
  logic [12:0] n_out;
  logic [1:0]  bram_owner;
  logic        busy, frame_done, timeout_err, cfg_err;
  logic [15:0] frame_cnt;

  corr_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cfg_n       (cfg_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .abort       (abort),
    .err_clear   (err_clear),
    .recv1_start (recv1_start),
    .recv2_start (recv2_start),
    .proc_start  (proc_start),
    .send_start  (send_start),
    .recv1_done  (done_v[0]),
    .recv2_done  (done_v[1]),
    .proc_done   (done_v[2]),
    .send_done   (done_v[3]),
    .n_out       (n_out),
    .bram_owner  (bram_owner),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err),
    .cfg_err     (cfg_err)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    int id;
    int cyc;
  } ev_t;
  ev_t sb[$];

  logic [12:0] exp_n = '0;
  logic [15:0] exp_cnt = '0;
  int dly[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pulse_of(input int id);
    case (id)
      1:       return recv1_start;
      2:       return recv2_start;
      3:       return proc_start;
      4:       return send_start;
      default: return frame_done;
    endcase
  endfunction

  function automatic logic [1:0] own_of(input int id);
    case (id)
      1:       return 2'd1;
      2:       return 2'd2;
      3:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Pulse monitor: every start/frame_done pulse must match the head of the scoreboard
  always @(negedge aclk) begin
    for (int id = 1; id <= 5; id++) begin
      if (pulse_of(id) === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", id, 0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("pulse_id", id, e.id);
          chk("pulse_cyc", cyc, e.cyc);
          chk("pulse_n_out", n_out, exp_n);
          chk("pulse_owner", bram_owner, own_of(id));
          chk("pulse_busy", busy, (id < 5) ? 1 : 0);
        end
      end
    end
  end

  task automatic wait_pulse(input int id, output int k);
    bit found;
    found = 0;
    k = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge aclk);
      if (pulse_of(id) === 1'b1) begin
        found = 1;
        k = cyc;
      end
    end
    chk($sformatf("wait_pulse%0d", id), found, 1);
  endtask

  // Returns with the stage's done raised so it is sampled d cycles after the start edge
  task automatic do_stage(input int id, input int d, input int stray, input int off);
    int k;
    wait_pulse(id, k);
    cfg_valid = 1'b0;
    for (int j = 0; j < d - 1; j++) begin
      done_v = 4'b0000;
      if (stray != 0 && j == off) done_v[stray-1] = 1'b1;
      @(negedge aclk);
    end
    done_v = 4'b0000;
    done_v[id-1] = 1'b1;
  endtask

  task automatic handshake(input logic [12:0] n, input int nexp);
    int t;
    @(negedge aclk);
    chk("cfg_ready_hs", cfg_ready, 1);
    cfg_n = n;
    cfg_valid = 1'b1;
    exp_n = n;
    t = cyc + 1;
    for (int i = 0; i < nexp; i++) begin
      sb.push_back(ev_t'{i + 1, t});
      if (i < 4) t += dly[i];
    end
  endtask

  task automatic run_frame(input logic [12:0] n, input int ss, input int sid, input int soff);
    handshake(n, 5);
    for (int s = 1; s <= 4; s++) do_stage(s, dly[s-1], (s == ss) ? sid : 0, soff);
    @(negedge aclk);
    done_v = 4'b0000;
    exp_cnt++;
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("frame_tmo", timeout_err, 0);
    @(negedge aclk);
    chk("frame_done_low", frame_done, 0);
    chk("frame_idle", busy, 0);
  endtask

  initial begin
    int k;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_starts", {recv1_start, recv2_start, proc_start, send_start}, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", bram_owner, 0);
    chk("rst_n_out", n_out, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_flags", {frame_done, timeout_err, cfg_err}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready_after_rst", cfg_ready, 1);

    // Nominal frame
    dly = '{10, 10, 10, 10};
    run_frame(13'd4096, 0, 0, 0);
    chk("nom_n_out", n_out, 4096);

    // Done in a start cycle ignored; done coinciding with timeout expiry wins
    dly = '{5, 16, 2, 3};
    run_frame(13'h1FFF, 1, 1, 0);

    // Stray recv1_done during PROCESS ignored
    dly = '{3, 4, 6, 2};
    run_frame(13'd100, 3, 1, 2);

    // cfg_n == 0 rejected; set beats simultaneous clear
    @(negedge aclk);
    cfg_n = '0;
    cfg_valid = 1'b1;
    @(negedge aclk);
    cfg_valid = 1'b0;
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_busy", busy, 0);
    chk("zero_n_out", n_out, exp_n);
    chk("zero_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    err_clear = 1'b1;
    @(negedge aclk);
    cfg_valid = 1'b0;
    err_clear = 1'b0;
    chk("cfg_err_set_wins", cfg_err, 1);
    err_clear = 1'b1;
    @(negedge aclk);
    err_clear = 1'b0;
    chk("cfg_err_cleared", cfg_err, 0);

    // Timeout in PROCESS
    dly = '{10, 10, 0, 0};
    handshake(13'd777, 3);
    do_stage(1, 10, 0, 0);
    do_stage(2, 10, 0, 0);
    wait_pulse(3, k);
    done_v = 4'b0000;
    repeat (15) @(negedge aclk);
    chk("tmo_pre_busy", busy, 1);
    chk("tmo_pre_err", timeout_err, 0);
    @(negedge aclk);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_owner", bram_owner, 0);
    chk("tmo_cnt", frame_cnt, exp_cnt);
    chk("tmo_ready", cfg_ready, 0);
    cfg_n = 13'd5;
    cfg_valid = 1'b1;
    repeat (3) @(negedge aclk);
    cfg_valid = 1'b0;
    chk("tmo_blocked_ready", cfg_ready, 0);
    chk("tmo_blocked_busy", busy, 0);
    err_clear = 1'b1;
    @(negedge aclk);
    err_clear = 1'b0;
    chk("tmo_cleared", timeout_err, 0);
    chk("tmo_ready_back", cfg_ready, 1);

    // Abort together with recv2_done in LOAD_F2
    dly = '{6, 8, 0, 0};
    handshake(13'd321, 2);
    do_stage(1, 6, 0, 0);
    wait_pulse(2, k);
    done_v = 4'b0000;
    repeat (7) @(negedge aclk);
    done_v[1] = 1'b1;
    abort = 1'b1;
    @(negedge aclk);
    chk("abort_busy", busy, 0);
    chk("abort_owner", bram_owner, 0);
    chk("abort_ready_low", cfg_ready, 0);
    done_v = 4'b0000;
    abort = 1'b0;
    repeat (3) @(negedge aclk);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_cnt", frame_cnt, exp_cnt);

    // frame_cnt wrap
    @(negedge aclk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", frame_cnt, 16'hFFFF);
    dly = '{2, 2, 2, 2};
    run_frame(13'd4096, 0, 0, 0);
    chk("wrap_zero", frame_cnt, 0);

    // Reset in the middle of SEND
    dly = '{3, 3, 3, 20};
    handshake(13'd999, 4);
    do_stage(1, 3, 0, 0);
    do_stage(2, 3, 0, 0);
    do_stage(3, 3, 0, 0);
    wait_pulse(4, k);
    done_v = 4'b0000;
    repeat (4) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    exp_n = '0;
    exp_cnt = '0;
    chk("mrst_busy", busy, 0);
    chk("mrst_owner", bram_owner, 0);
    chk("mrst_n_out", n_out, 0);
    chk("mrst_cnt", frame_cnt, 0);
    chk("mrst_ready", cfg_ready, 0);
    chk("mrst_starts", {recv1_start, recv2_start, proc_start, send_start, frame_done}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mrst_ready_back", cfg_ready, 1);
    repeat (5) @(negedge aclk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/corr_sequencer.md
CORR_SEQUENCER -- requirements
Module: corr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, max cycles a stage may run before done; 0 disables the timeout.
REQ-002 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have ports cfg_n  input  13  frame length N; cfg_valid  input  1; cfg_ready  output  1  (run-request handshake).
REQ-005 SHALL have port abort  input  1  level; forces return to IDLE.
REQ-006 SHALL have port err_clear  input  1  pulse; clears sticky error flags.
REQ-007 SHALL have ports recv1_start, recv2_start, proc_start, send_start  output  1 each  one-cycle stage start pulses.
REQ-008 SHALL have ports recv1_done, recv2_done, proc_done, send_done  input  1 each  stage completion pulses.
REQ-009 SHALL have port n_out  output  13  latched N, driven to all stages.
REQ-010 SHALL have port bram_owner  output  2  shared-BRAM port mux select: 0 none, 1 F1 loader, 2 F2 loader, 3 processor.
REQ-011 SHALL have ports busy  output  1; frame_done  output  1  (one-cycle pulse); frame_cnt  output  16.
REQ-012 SHALL have ports timeout_err  output  1  sticky; cfg_err  output  1  sticky.

Function
REQ-013 SHALL implement states IDLE, LOAD_F1, LOAD_F2, PROCESS, SEND; all outputs registered.
REQ-014 SHALL assert cfg_ready only in IDLE with abort low and timeout_err low.
REQ-015 On cfg_valid&cfg_ready with cfg_n!=0: latch n_out<=cfg_n, go LOAD_F1, recv1_start=1 in the first LOAD_F1 cycle.
REQ-016 On cfg_valid&cfg_ready with cfg_n==0: stay IDLE, set cfg_err, n_out unchanged, no start pulse.
REQ-017 Transitions: LOAD_F1 --recv1_done--> LOAD_F2; LOAD_F2 --recv2_done--> PROCESS; PROCESS --proc_done--> SEND; SEND --send_done--> IDLE.
REQ-018 Each start pulse SHALL be high exactly in the first cycle of its state (edge that enters the state sets it, next edge clears it).
REQ-019 Done inputs SHALL be sampled only in the matching state and not in that state's start cycle; done of any other stage or in IDLE ignored.
REQ-020 Transition on done SHALL occur at the same edge that samples it; next-stage start high in the following cycle (1-cycle done-to-start latency).
REQ-021 On SEND->IDLE: frame_done=1 for one cycle, frame_cnt+1, wrapping 0xFFFF->0x0000.
REQ-022 bram_owner: IDLE 0, LOAD_F1 1, LOAD_F2 2, PROCESS 3, SEND 0; changes at the same edge as the state.
REQ-023 busy=1 in any state except IDLE.
REQ-024 n_out SHALL remain constant from handshake until return to IDLE.
REQ-025 Per-stage cycle counter SHALL clear on state entry, increment each cycle in a non-IDLE state; at count==TIMEOUT_CYCLES-1 without done: set timeout_err, go IDLE, no frame_done, frame_cnt unchanged.
REQ-026 Done in the same cycle as timeout expiry SHALL win (normal transition, no error).
REQ-027 abort high in a non-IDLE state SHALL go IDLE at next edge; abort wins over done and timeout in the same cycle; no frame_done; no further start pulses.
REQ-028 err_clear SHALL clear timeout_err and cfg_err at next edge; a simultaneous setting event wins (flag stays set).
REQ-029 While timeout_err is set no new run SHALL start.

Reset
REQ-030 aresetn low SHALL immediately force: state IDLE, all start pulses 0, cfg_ready 0, busy 0, bram_owner 0, n_out 0, frame_cnt 0, frame_done 0, timeout_err 0, cfg_err 0, counters 0.
REQ-031 Reset mid-run SHALL abandon the frame with no pulses; cfg_ready returns to 1 in the first cycle after release.

Verification
REQ-032 Nominal: cfg_n=4096 handshake, each done returned 10 cycles after its start -> starts in order, one per stage, 1-cycle done-to-start, frame_done once, frame_cnt 0->1, n_out=4096 throughout.
REQ-033 Timeout: TIMEOUT_CYCLES=16, proc_done withheld -> IDLE 16 cycles after PROCESS entry, timeout_err=1, cfg_ready=0 until err_clear pulse.
REQ-034 Abort: abort and recv2_done together in LOAD_F2 -> IDLE, proc_start never asserted, frame_cnt unchanged.
REQ-035 Stray/zero: recv1_done during PROCESS ignored; cfg_n=0 handshake -> cfg_err=1, state stays IDLE.
REQ-036 Wrap and reset: preload to 65535 frames (or force), one more frame -> frame_cnt=0; aresetn low mid-SEND -> all outputs at reset values immediately.
